// File: rtl/xgmii2gmii.sv
// XGMII (72-bit {txc,txd}) to GMII transmit serializer fed from an external FIFO.
// Define XGMII2GMII_STATS_EN to build the frame/underrun statistics counters.
module xgmii2gmii #(
  parameter int IFG_MIN = 12,
  parameter int CNT_W   = 32
) (
  input  logic             gmii_clk,
  input  logic             sys_rst,
  input  logic [71:0]      txq_dout,
  input  logic             txq_empty,
  output logic             txq_rd_en,
  output logic             gmii_tx_en,
  output logic [7:0]       gmii_txd,
  output logic             gmii_tx_er,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] underrun_count
);

  // state  | meaning
  // IDLE   | wait for a word, issue read
  // FETCH  | inspect fetched word, start frame on FB in lane 0
  // DATA   | serialise one lane per cycle, prefetch at lane 6
  // DROP   | discard words after underrun until one holds FD
  // IFG    | hold tx_en low until the gap counter expires
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_DROP, S_IFG} state_t;

  // IDLE+FETCH (and the extra error cycle on underrun) already count as low cycles.
  localparam int IFG_LD_TERM = (IFG_MIN > 3) ? IFG_MIN - 3 : 0;
  localparam int IFG_LD_UNDR = (IFG_MIN > 2) ? IFG_MIN - 2 : 0;

  state_t      r_state, w_state_nx;
  logic [71:0] r_word;
  logic [2:0]  r_idx, w_idx_nx;
  logic        r_underrun, w_underrun_nx;
  logic        r_drop_vld, w_drop_vld_nx;
  logic [15:0] r_ifg;
  logic        r_tx_en, w_tx_en_nx;
  logic [7:0]  r_txd, w_txd_nx;
  logic        r_tx_er, w_tx_er_nx;
  logic        w_rd_en, w_load, w_ld_term, w_ld_undr;
  logic        w_frame_inc, w_undr_inc;
  logic        w_start, w_dout_fd, w_fd67, w_lane_c;
  logic [7:0]  w_ctrl, w_lane_d;

  assign w_ctrl   = r_word[71:64];
  assign w_lane_c = w_ctrl[r_idx];
  assign w_lane_d = r_word[{r_idx, 3'b000} +: 8];
  assign w_start  = txq_dout[64] && (txq_dout[7:0] == 8'hFB);
  assign w_fd67   = (r_word[70] && (r_word[55:48] == 8'hFD)) ||
                    (r_word[71] && (r_word[63:56] == 8'hFD));

  always_comb begin
    w_dout_fd = 1'b0;
    for (int i = 0; i < 8; i++)
      if (txq_dout[64+i] && (txq_dout[8*i +: 8] == 8'hFD)) w_dout_fd = 1'b1;
  end

  always_comb begin
    w_state_nx    = r_state;
    w_idx_nx      = r_idx;
    w_underrun_nx = r_underrun;
    w_drop_vld_nx = 1'b0;
    w_rd_en       = 1'b0;
    w_load        = 1'b0;
    w_ld_term     = 1'b0;
    w_ld_undr     = 1'b0;
    w_frame_inc   = 1'b0;
    w_undr_inc    = 1'b0;
    w_tx_en_nx    = 1'b0;
    w_txd_nx      = 8'h00;
    w_tx_er_nx    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!txq_empty) begin
          w_rd_en    = 1'b1;
          w_state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_start) begin
          w_load        = 1'b1;
          w_tx_en_nx    = 1'b1;
          w_txd_nx      = 8'h55;
          w_idx_nx      = 3'd1;
          w_underrun_nx = 1'b0;
          w_state_nx    = S_DATA;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_DATA: begin
        if ((r_idx == 3'd0) && r_underrun) begin
          w_tx_en_nx    = 1'b1;
          w_tx_er_nx    = 1'b1;
          w_undr_inc    = 1'b1;
          w_ld_undr     = 1'b1;
          w_underrun_nx = 1'b0;
          w_state_nx    = S_DROP;
        end else if (w_lane_c && (w_lane_d == 8'hFD)) begin
          w_frame_inc = 1'b1;
          w_ld_term   = 1'b1;
          w_idx_nx    = 3'd0;
          w_state_nx  = S_IFG;
        end else begin
          w_tx_en_nx = 1'b1;
          w_tx_er_nx = w_lane_c;
          w_txd_nx   = w_lane_c ? 8'hFE : w_lane_d;
          w_idx_nx   = r_idx + 3'd1;
          if ((r_idx == 3'd6) && !w_fd67) begin
            if (!txq_empty) w_rd_en = 1'b1;
            else            w_underrun_nx = 1'b1;
          end
          if ((r_idx == 3'd7) && !r_underrun) w_load = 1'b1;
        end
      end
      S_DROP: begin
        if (r_drop_vld && w_dout_fd) begin
          w_state_nx = S_IFG;
        end else if (!txq_empty) begin
          w_rd_en       = 1'b1;
          w_drop_vld_nx = 1'b1;
        end
      end
      S_IFG: begin
        if (r_ifg == 16'd0) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge gmii_clk) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_word     <= '0;
      r_idx      <= '0;
      r_underrun <= 1'b0;
      r_drop_vld <= 1'b0;
      r_ifg      <= '0;
      r_tx_en    <= 1'b0;
      r_txd      <= 8'h00;
      r_tx_er    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_idx      <= w_idx_nx;
      r_underrun <= w_underrun_nx;
      r_drop_vld <= w_drop_vld_nx;
      r_tx_en    <= w_tx_en_nx;
      r_txd      <= w_txd_nx;
      r_tx_er    <= w_tx_er_nx;
      if (w_load) r_word <= txq_dout;
      if (w_ld_term)           r_ifg <= 16'(IFG_LD_TERM);
      else if (w_ld_undr)      r_ifg <= 16'(IFG_LD_UNDR);
      else if (r_ifg != 16'd0) r_ifg <= r_ifg - 16'd1;
    end
  end

  assign txq_rd_en  = w_rd_en & ~sys_rst;
  assign gmii_tx_en = r_tx_en;
  assign gmii_txd   = r_txd;
  assign gmii_tx_er = r_tx_er;

`ifdef XGMII2GMII_STATS_EN
  logic [CNT_W-1:0] r_frame_cnt, r_undr_cnt;

  always_ff @(posedge gmii_clk) begin
    if (sys_rst) begin
      r_frame_cnt <= '0;
      r_undr_cnt  <= '0;
    end else begin
      if (w_frame_inc) r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      if (w_undr_inc)  r_undr_cnt  <= r_undr_cnt + CNT_W'(1);
    end
  end

  assign frame_count    = r_frame_cnt;
  assign underrun_count = r_undr_cnt;
`else
  logic w_unused_stats;
  assign w_unused_stats = w_frame_inc | w_undr_inc;
  assign frame_count    = '0;
  assign underrun_count = '0;
`endif

endmodule

// File: tb/tb_xgmii2gmii.sv
// Directed bench for xgmii2gmii: FIFO model, GMII capture monitor, one task per scenario.
module tb_xgmii2gmii;
  logic        gmii_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [71:0] txq_dout = '0;
  logic        txq_empty = 1'b1;
  logic        txq_rd_en, gmii_tx_en, gmii_tx_er;
  logic [7:0]  gmii_txd;
  logic [31:0] frame_count, underrun_count;

`ifdef XGMII2GMII_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [71:0] PRE   = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] TERM0 = {8'hFF, 64'h07070707070707FD};
  localparam logic [71:0] IDLEW = {8'hFF, 64'h0707070707070707};

  xgmii2gmii #(.IFG_MIN(12), .CNT_W(32)) dut (
    .gmii_clk(gmii_clk), .sys_rst(sys_rst), .txq_dout(txq_dout), .txq_empty(txq_empty),
    .txq_rd_en(txq_rd_en), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
    .gmii_tx_er(gmii_tx_er), .frame_count(frame_count), .underrun_count(underrun_count)
  );

  always #5 gmii_clk = ~gmii_clk;

  int errors = 0, checks = 0;
  logic [71:0] q[$];
  bit rd_s, prev_en, seen, lat_arm;
  int cyc, fall_cnt, low_run, rd_cyc, en_cyc;
  bit [8:0] cap_q[$];
  int gap_q[$];

  // FIFO model: data valid the cycle after a read strobe.
  always @(posedge gmii_clk) begin
    #1;
    if (rd_s && q.size() > 0) txq_dout = q.pop_front();
    txq_empty = (q.size() == 0);
  end

  always @(negedge gmii_clk) begin
    cyc++;
    rd_s = txq_rd_en;
    if (lat_arm && txq_rd_en && rd_cyc < 0) rd_cyc = cyc;
    if (gmii_tx_en) begin
      cap_q.push_back({gmii_tx_er, gmii_txd});
      if (!prev_en) begin
        if (seen) gap_q.push_back(low_run);
        seen = 1'b1;
        if (lat_arm) begin en_cyc = cyc; lat_arm = 1'b0; end
      end
      low_run = 0;
    end else begin
      low_run++;
      if (prev_en) fall_cnt++;
    end
    prev_en = gmii_tx_en;
  end

  function automatic logic [71:0] mk_data(input logic [7:0] b);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = b + 8'(i);
    return w;
  endfunction

  task automatic wait_fall(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge gmii_clk);
      #1;
      if (fall_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    q.push_back(IDLEW);
    repeat (3) @(posedge gmii_clk);
    #1;
    checks++; if (gmii_tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b want 0", gmii_tx_en); end
    checks++; if (gmii_txd !== 8'h00) begin errors++; $display("FAIL reset_txd: got %h want 00", gmii_txd); end
    checks++; if (gmii_tx_er !== 1'b0) begin errors++; $display("FAIL reset_tx_er: got %b want 0", gmii_tx_er); end
    checks++; if (txq_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", txq_rd_en); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frame_count); end
    checks++; if (underrun_count !== 32'd0) begin errors++; $display("FAIL reset_underruns: got %0d want 0", underrun_count); end
    sys_rst = 1'b0;
    repeat (10) @(posedge gmii_clk);
    #1;
    checks++; if (cap_q.size() !== 0) begin errors++; $display("FAIL idle_word_ignored: got %0d bytes want 0", cap_q.size()); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL idle_word_consumed: got %0d left want 0", q.size()); end
  endtask

  task automatic test_basic_frame();
    int f0; bit ok; bit [8:0] exp;
    cap_q.delete(); rd_cyc = -1; lat_arm = 1'b1; f0 = fall_cnt;
    q.push_back(PRE);
    for (int k = 0; k < 8; k++) q.push_back(mk_data(8'h10 + 8'(8*k)));
    q.push_back(TERM0);
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: frame end not seen"); end
    checks++; if (en_cyc - rd_cyc !== 2) begin errors++; $display("FAIL basic_latency: got %0d want 2", en_cyc - rd_cyc); end
    checks++; if (cap_q.size() !== 72) begin errors++; $display("FAIL basic_length: got %0d want 72", cap_q.size()); end
    for (int i = 0; i < 72 && i < cap_q.size(); i++) begin
      exp = (i < 7) ? 9'h055 : (i == 7) ? 9'h0D5 : {1'b0, 8'h10 + 8'(i - 8)};
      checks++; if (cap_q[i] !== exp) begin errors++; $display("FAIL basic_byte%0d: got %h want %h", i, cap_q[i], exp); end
    end
    checks++; if (frame_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL basic_frames: got %0d", frame_count); end
  endtask

  task automatic test_term_lane3();
    int f0; bit ok; bit [8:0] exp;
    cap_q.delete(); f0 = fall_cnt;
    q.push_back(PRE); q.push_back(mk_data(8'h80)); q.push_back({8'hF8, 64'h07070707FDA2A1A0});
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL term3_timeout: frame end not seen"); end
    checks++; if (cap_q.size() !== 19) begin errors++; $display("FAIL term3_length: got %0d want 19", cap_q.size()); end
    for (int i = 0; i < 3 && 16 + i < cap_q.size(); i++) begin
      exp = {1'b0, 8'hA0 + 8'(i)};
      checks++; if (cap_q[16+i] !== exp) begin errors++; $display("FAIL term3_byte%0d: got %h want %h", i, cap_q[16+i], exp); end
    end
    checks++; if (frame_count !== (STATS ? 32'd2 : 32'd0)) begin errors++; $display("FAIL term3_frames: got %0d", frame_count); end
  endtask

  task automatic test_error_fe();
    int f0; bit ok;
    cap_q.delete(); f0 = fall_cnt;
    q.push_back(PRE); q.push_back({8'h24, 64'hE7E6FBE4E3FEE1E0}); q.push_back(TERM0);
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fe_timeout: frame end not seen"); end
    checks++; if (cap_q.size() !== 16) begin errors++; $display("FAIL fe_length: got %0d want 16", cap_q.size()); end
    if (cap_q.size() >= 16) begin
      checks++; if (cap_q[9] !== 9'h0E1) begin errors++; $display("FAIL fe_lane1: got %h want 0e1", cap_q[9]); end
      checks++; if (cap_q[10] !== 9'h1FE) begin errors++; $display("FAIL fe_lane2: got %h want 1fe", cap_q[10]); end
      checks++; if (cap_q[11] !== 9'h0E3) begin errors++; $display("FAIL fe_lane3: got %h want 0e3", cap_q[11]); end
      checks++; if (cap_q[13][8] !== 1'b1) begin errors++; $display("FAIL fb_lane5_er: got %b want 1", cap_q[13][8]); end
      checks++; if (cap_q[15] !== 9'h0E7) begin errors++; $display("FAIL fe_lane7: got %h want 0e7", cap_q[15]); end
    end
  endtask

  task automatic test_back_to_back();
    int f0; bit ok;
    cap_q.delete(); gap_q.delete(); f0 = fall_cnt;
    for (int n = 0; n < 2; n++) begin
      q.push_back(PRE); q.push_back(mk_data(8'hC0)); q.push_back(TERM0);
    end
    wait_fall(f0 + 2, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: two frame ends not seen"); end
    checks++; if (cap_q.size() !== 32) begin errors++; $display("FAIL b2b_length: got %0d want 32", cap_q.size()); end
    checks++; if (gap_q.size() !== 2) begin errors++; $display("FAIL b2b_gaps: got %0d want 2", gap_q.size()); end
    if (gap_q.size() == 2) begin
      checks++; if (gap_q[1] !== 12) begin errors++; $display("FAIL b2b_ifg: got %0d want 12", gap_q[1]); end
    end
    checks++; if (frame_count !== (STATS ? 32'd5 : 32'd0)) begin errors++; $display("FAIL b2b_frames: got %0d", frame_count); end
  endtask

  task automatic test_underrun();
    int f0; bit ok; int ers;
    cap_q.delete(); f0 = fall_cnt;
    q.push_back(PRE); q.push_back(mk_data(8'h20));
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL undr_timeout: abort not seen"); end
    checks++; if (cap_q.size() !== 17) begin errors++; $display("FAIL undr_length: got %0d want 17", cap_q.size()); end
    if (cap_q.size() >= 17) begin
      checks++; if (cap_q[15] !== 9'h027) begin errors++; $display("FAIL undr_lane7: got %h want 027", cap_q[15]); end
      checks++; if (cap_q[16] !== 9'h100) begin errors++; $display("FAIL undr_err_cycle: got %h want 100", cap_q[16]); end
    end
    cap_q.delete(); f0 = fall_cnt;
    q.push_back(mk_data(8'h30)); q.push_back({8'h01, 64'h11223344556677FB}); q.push_back(TERM0);
    q.push_back(PRE); q.push_back(mk_data(8'h40)); q.push_back(TERM0);
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL undr_next_timeout: next frame not seen"); end
    checks++; if (cap_q.size() !== 16) begin errors++; $display("FAIL undr_next_length: got %0d want 16", cap_q.size()); end
    if (cap_q.size() >= 16) begin
      checks++; if (cap_q[0] !== 9'h055) begin errors++; $display("FAIL undr_next_first: got %h want 055", cap_q[0]); end
      checks++; if (cap_q[15] !== 9'h047) begin errors++; $display("FAIL undr_next_last: got %h want 047", cap_q[15]); end
    end
    ers = 0;
    foreach (cap_q[i]) if (cap_q[i][8]) ers++;
    checks++; if (ers !== 0) begin errors++; $display("FAIL undr_next_clean: got %0d error bytes want 0", ers); end
    checks++; if (underrun_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL undr_count: got %0d", underrun_count); end
    checks++; if (frame_count !== (STATS ? 32'd6 : 32'd0)) begin errors++; $display("FAIL undr_frames: got %0d", frame_count); end
  endtask

  task automatic test_reset_midframe();
    int f0; bit ok;
    cap_q.delete();
    q.push_back(PRE);
    for (int k = 0; k < 8; k++) q.push_back(mk_data(8'h50 + 8'(8*k)));
    q.push_back(TERM0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge gmii_clk);
      if (cap_q.size() >= 10) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_start: frame did not start"); end
    @(posedge gmii_clk); #1;
    sys_rst = 1'b1;
    checks++; if (txq_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en: got %b want 0", txq_rd_en); end
    @(posedge gmii_clk); #1;
    sys_rst = 1'b0;
    checks++; if ({gmii_tx_en, gmii_tx_er, gmii_txd} !== 10'h000) begin errors++; $display("FAIL rstmid_outputs: got en=%b er=%b txd=%h want all 0", gmii_tx_en, gmii_tx_er, gmii_txd); end
    checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL rstmid_frames_clr: got %0d want 0", frame_count); end
    @(negedge gmii_clk); #1;
    cap_q.delete(); f0 = fall_cnt;
    q.push_back(IDLEW); q.push_back(IDLEW);
    q.push_back(PRE); q.push_back(mk_data(8'h60)); q.push_back(TERM0);
    wait_fall(f0 + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: clean frame not seen"); end
    checks++; if (cap_q.size() !== 16) begin errors++; $display("FAIL rstmid_length: got %0d want 16", cap_q.size()); end
    if (cap_q.size() >= 16) begin
      checks++; if (cap_q[0] !== 9'h055) begin errors++; $display("FAIL rstmid_first: got %h want 055", cap_q[0]); end
      checks++; if (cap_q[8] !== 9'h060) begin errors++; $display("FAIL rstmid_data0: got %h want 060", cap_q[8]); end
    end
    checks++; if (frame_count !== (STATS ? 32'd1 : 32'd0)) begin errors++; $display("FAIL rstmid_frames: got %0d", frame_count); end
    checks++; if (underrun_count !== 32'd0) begin errors++; $display("FAIL rstmid_underruns: got %0d want 0", underrun_count); end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_term_lane3();
    test_error_fe();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    repeat (5) @(posedge gmii_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
